// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes and controller states.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_MUL  = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Multiply is the only opcode that takes the multi-cycle path.
  function automatic logic is_mul(input logic [3:0] op);
    return op == ALU_MUL;
  endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps.
// done is asserted combinationally on the final step together with product,
// so the parent can register the result on that same edge.
module seq_alu_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;

  // Accumulate the current partial product (wraps mod 2^WIDTH).
  always_comb begin
    acc_next = mplier[0] ? acc + mcand : acc;
  end

  // Load operands on start, then step once per cycle until the count runs out.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: operand registers are reset as well as the counter, so an aborted
    // multiply leaves no stale partial state behind.
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      // NOTE: non-blocking assignments keep every register update in this
      // block reading the pre-edge values, which is what a shift-add step needs.
      mcand  <= multiplicand;
      mplier <= multiplier;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  assign done    = (cnt == CW'(1));
  assign product = acc_next;

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU with registered result and flags. Single-cycle ops complete
// on the accept edge; multiply runs through the iterative sub-module.
module seq_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
  } alu_out_t;

  // Every non-multiply op. Add, sub, and the unused opcodes share one adder;
  // sub is a + ~b + 1 so carry is NOT-borrow.
  function automatic alu_out_t alu_eval(input logic [3:0]       op,
                                        input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y);
    alu_out_t         o;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] yy;
    logic             cin;
    logic [SHW-1:0]   sh;
    o   = '0;
    sh  = y[SHW-1:0];
    cin = (op == ALU_SUB);
    yy  = cin ? ~y : y;
    sum = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, cin};
    case (op)
      ALU_AND:  o.res = x & y;
      ALU_OR:   o.res = x | y;
      ALU_SLT:  o.res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      ALU_SLTU: o.res = {{(WIDTH-1){1'b0}}, (x < y)};
      ALU_XOR:  o.res = x ^ y;
      ALU_NOR:  o.res = ~(x | y);
      ALU_SLL:  o.res = x << sh;
      ALU_SRL:  o.res = x >> sh;
      ALU_SRA:  o.res = $signed(x) >>> sh;
      default: begin
        o.res = sum[WIDTH-1:0];
        o.c   = sum[WIDTH];
        o.v   = (x[WIDTH-1] == yy[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      end
    endcase
    return o;
  endfunction

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  alu_out_t         alu_now;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul(alu_control);

  // Evaluate the presented operands every cycle; used only on accept.
  always_comb begin
    alu_now = alu_eval(alu_control, a, b);
  end

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (mul_start),
    .multiplicand (a),
    .multiplier   (b),
    .done         (mul_done),
    .product      (mul_product)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state: DONE with a fresh accept dispatches exactly like IDLE.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = is_mul(alu_control) ? S_MUL : S_DONE;
      S_MUL:  if (mul_done) state_next = S_DONE;
      S_DONE: begin
        if (accept)         state_next = is_mul(alu_control) ? S_MUL : S_DONE;
        else if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Result and flag registers: loaded on a single-cycle accept or on the
  // final multiply step, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept && !is_mul(alu_control)) begin
      result   <= alu_now.res;
      carry    <= alu_now.c;
      overflow <= alu_now.v;
    end else if (state == S_MUL && mul_done) begin
      result   <= mul_product;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes model results into a queue,
// an independent monitor pops and compares on each output transfer.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   alu_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;

  logic         in_valid8;
  logic         in_ready8;
  logic [7:0]   a8;
  logic [7:0]   b8;
  logic [3:0]   op8;
  logic         out_valid8;
  logic         out_ready8;
  logic [7:0]   result8;
  logic         zero8;
  logic         carry8;
  logic         overflow8;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .carry(carry),
    .overflow(overflow)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .alu_control(op8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .zero(zero8), .carry(carry8),
    .overflow(overflow8)
  );

  typedef struct {
    logic [W-1:0] res;
    bit           c;
    bit           v;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model from the arithmetic definitions (wide signed math for V).
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      s;
    logic [W:0]  u;
    logic [63:0] p;
    int          sh;
    e.c = 1'b0;
    e.v = 1'b0;
    sh  = int'(y[4:0]);
    case (op)
      4'd1: begin
        e.res = x - y;
        e.c   = (x >= y);
        s     = longint'($signed(x)) - longint'($signed(y));
        e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2:  e.res = x & y;
      4'd3:  e.res = x | y;
      4'd4:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd5:  e.res = (x < y) ? 32'd1 : 32'd0;
      4'd6:  e.res = x ^ y;
      4'd7:  e.res = ~(x | y);
      4'd8:  e.res = x << sh;
      4'd9:  e.res = x >> sh;
      4'd10: e.res = (x >> sh) | (x[W-1] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd11: begin
        p     = {32'd0, x} * {32'd0, y};
        e.res = p[31:0];
      end
      default: begin
        u     = {1'b0, x} + {1'b0, y};
        e.res = u[W-1:0];
        e.c   = u[W];
        s     = longint'($signed(x)) + longint'($signed(y));
        e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
    endcase
    return e;
  endfunction

  // Monitor: a transfer happens at the next posedge whenever valid && ready.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h expected none", result);
        end else begin
          mon_e = sb_q.pop_front();
          check("result",   64'(result),   64'(mon_e.res));
          check("carry",    64'(carry),    64'(mon_e.c));
          check("overflow", 64'(overflow), 64'(mon_e.v));
          check("zero",     64'(zero),     64'(mon_e.res == '0));
        end
      end
    end
  end

  // Single driver of out_ready: random only while rand_ready is set.
  task automatic tick();
    @(negedge clk);
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int waits);
    exp_t e;
    e     = model(op, x, y);
    waits = 0;
    tick();
    in_valid    = 1'b1;
    alu_control = op;
    a           = x;
    b           = y;
    #1;
    while (!in_ready && waits < 200) begin
      tick();
      #1;
      waits++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got in_ready 0 expected 1");
      in_valid = 1'b0;
    end else begin
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Cycles from the accept edge until out_valid, and cycles with in_ready low.
  task automatic measure(input string name, input int exp_lat, input int exp_low);
    int n;
    int low;
    n   = 0;
    low = 0;
    do begin
      tick();
      #1;
      n++;
      if (!in_ready) low++;
    end while (!out_valid && n < 100);
    check({name, "_latency"}, 64'(n), 64'(exp_lat));
    if (exp_low >= 0) check({name, "_in_ready_low"}, 64'(low), 64'(exp_low));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0]   d_op [8];
  logic [W-1:0] d_a  [8];
  logic [W-1:0] d_b  [8];
  logic [15:0]  p8;

  initial begin
    int w;
    int n;
    logic [W-1:0] hold_res;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; alu_control = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; out_ready8 = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_zero",      64'(zero),      64'd1);
    check("rst_carry",     64'(carry),     64'd0);
    check("rst_overflow",  64'(overflow),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Add overflow with explicit expected constants and one-cycle latency
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, w);
    measure("add", 1, -1);
    check("add_ovf_result", 64'(result),   64'h8000_0000);
    check("add_ovf_flag",   64'(overflow), 64'd1);
    check("add_ovf_carry",  64'(carry),    64'd0);
    check("add_ovf_zero",   64'(zero),     64'd0);
    drain();

    // Directed single-cycle ops
    d_op[0] = ALU_SUB;  d_a[0] = 32'd5;         d_b[0] = 32'd5;
    d_op[1] = ALU_SLT;  d_a[1] = 32'hFFFF_FFFF; d_b[1] = 32'd1;
    d_op[2] = ALU_SLTU; d_a[2] = 32'hFFFF_FFFF; d_b[2] = 32'd1;
    d_op[3] = ALU_SRA;  d_a[3] = 32'h8000_0000; d_b[3] = 32'd4;
    d_op[4] = ALU_SRL;  d_a[4] = 32'h8000_0000; d_b[4] = 32'd4;
    d_op[5] = ALU_SLL;  d_a[5] = 32'd1;         d_b[5] = 32'd31;
    d_op[6] = ALU_SLL;  d_a[6] = 32'hA5A5_1234; d_b[6] = 32'd0;
    d_op[7] = 4'd14;    d_a[7] = 32'hFFFF_FFFF; d_b[7] = 32'd1;
    for (int i = 0; i < 8; i++) issue(d_op[i], d_a[i], d_b[i], w);
    drain();

    // Multiply latency
    issue(ALU_MUL, 32'h1234, 32'h5678, w);
    measure("mul", W + 1, W);
    drain();

    // Backpressure: result held for 5 cycles, then a 4-op stream
    out_ready = 1'b0;
    issue(ALU_ADD, 32'hFFFF_FFF0, 32'h20, w);
    measure("bp_add", 1, -1);
    hold_res = 32'h10;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_result",    64'(result),    64'(hold_res));
      check("bp_carry",     64'(carry),     64'd1);
      check("bp_in_ready",  64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    issue(ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, w); check("stream_wait0", 64'(w), 64'd0);
    issue(ALU_SUB, 32'd3, 32'd7, w);                 check("stream_wait1", 64'(w), 64'd0);
    issue(ALU_NOR, 32'd0, 32'd0, w);                 check("stream_wait2", 64'(w), 64'd0);
    issue(ALU_OR,  32'h1, 32'h8000_0000, w);         check("stream_wait3", 64'(w), 64'd0);
    drain();

    // Randomised traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 7) == 0) ra = 32'h7FFF_FFFF;
      if ($urandom_range(0, 7) == 0) rb = 32'h8000_0000;
      issue(4'($urandom_range(0, 15)), ra, rb, w);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();

    // Reset in the middle of a multiply
    issue(ALU_MUL, 32'hDEAD_BEEF, 32'h1234_5678, w);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result",    64'(result),    64'd0);
    check("midrst_zero",      64'(zero),      64'd1);
    sb_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("postrst_in_ready", 64'(in_ready), 64'd1);
    issue(ALU_ADD, 32'd100, 32'd23, w);
    measure("postrst_add", 1, -1);
    drain();

    // WIDTH=8 multiply: FF*FF keeps the low byte, WIDTH+1 cycles
    p8 = 16'h00FF * 16'h00FF;
    @(negedge clk);
    in_valid8 = 1'b1; op8 = ALU_MUL; a8 = 8'hFF; b8 = 8'hFF; out_ready8 = 1'b1;
    #1;
    check("w8_in_ready", 64'(in_ready8), 64'd1);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!out_valid8 && n < 50);
    check("w8_mul_latency", 64'(n), 64'd9);
    check("w8_mul_result",  64'(result8), 64'(p8[7:0]));
    check("w8_mul_carry",   64'(carry8), 64'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
